// File: rtl/bme280_sample_scheduler.sv
`default_nettype none
// =====================================================================================
// bme280_sample_scheduler: single-shot BME280 sequencer with timeout/retry supervision
// and a one-deep valid/ready sample buffer.                                   Rev 1.0
// =====================================================================================
module bme280_sample_scheduler #(
   parameter int DATA_W       = 96,
   parameter int INTERVAL_CYC = 1000000,
   parameter int TIMEOUT_CYC  = 500000,
   parameter int BACKOFF_CYC  = 1000,
   parameter int MAX_RETRY    = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run,
   input  logic              trigger,
   input  logic              clear_fault,
   output logic              bme_enable,
   output logic              bme_continuous,
   input  logic              bme_busy,
   input  logic              bme_valid,
   input  logic [1:0]        bme_error,
   input  logic [DATA_W-1:0] bme_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overrun,
   output logic              fault,
   output logic [2:0]        last_err,
   output logic [15:0]       sample_count
);

   localparam int IW = (INTERVAL_CYC > 1) ? $clog2(INTERVAL_CYC) : 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int BW = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;

   localparam logic [IW-1:0] INTERVAL_LAST = IW'(INTERVAL_CYC - 1);
   localparam logic [TW-1:0] TIMER_LAST    = TW'(TIMEOUT_CYC - 1);
   localparam logic [BW-1:0] BACKOFF_LAST  = BW'(BACKOFF_CYC - 1);
   localparam logic [3:0]    RETRY_LIMIT   = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_BACKOFF   = 3'd4,
      S_FAULT     = 3'd5
   } state_t;

   state_t          state;
   state_t          next_state;

   logic [IW-1:0]   interval_cnt;
   logic [TW-1:0]   timer;
   logic [BW-1:0]   backoff_cnt;
   logic [3:0]      retry_cnt;
   logic            pending;

   logic            interval_hit;
   logic            request;
   logic            capture;
   logic            fail;
   logic [2:0]      fail_code;

   assign interval_hit = run && (interval_cnt == '0);
   assign request      = trigger || interval_hit;

   assign bme_enable     = (state == S_START);
   assign bme_continuous = 1'b0;
   assign fault          = (state == S_FAULT);

   // ---------------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Failure is resolved in the cycle it is detected; there is no separate FAIL cycle.
   always_comb begin
      next_state = state;
      capture    = 1'b0;
      fail       = 1'b0;
      fail_code  = 3'b000;
      case (state)
         S_IDLE: begin
            if (request || pending) begin
               next_state = S_START;
            end
         end
         S_START: begin
            next_state = S_WAIT_BUSY;
         end
         S_WAIT_BUSY, S_WAIT_DONE: begin
            if (bme_valid) begin
               if (bme_error == 2'b00) begin
                  capture    = 1'b1;
                  next_state = S_IDLE;
               end else begin
                  fail      = 1'b1;
                  fail_code = {1'b0, bme_error};
               end
            end else if (timer == TIMER_LAST) begin
               fail      = 1'b1;
               fail_code = 3'b100;
            end else if ((state == S_WAIT_BUSY) && bme_busy) begin
               next_state = S_WAIT_DONE;
            end
            if (fail) begin
               next_state = (retry_cnt < RETRY_LIMIT) ? S_BACKOFF : S_FAULT;
            end
         end
         S_BACKOFF: begin
            if (backoff_cnt == '0) begin
               next_state = S_START;
            end
         end
         S_FAULT: begin
            if (clear_fault) begin
               next_state = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------
   // Request sources and transaction supervision
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         interval_cnt <= INTERVAL_LAST;
         pending      <= 1'b0;
         timer        <= '0;
         backoff_cnt  <= '0;
         retry_cnt    <= 4'd0;
         last_err     <= 3'b000;
      end else begin
         if (!run || (interval_cnt == '0)) begin
            interval_cnt <= INTERVAL_LAST;
         end else begin
            interval_cnt <= interval_cnt - IW'(1);
         end

         // IDLE consumes a request directly, so pending only accumulates elsewhere.
         if ((state == S_IDLE) || (state == S_FAULT)) begin
            pending <= 1'b0;
         end else if (request) begin
            pending <= 1'b1;
         end

         if (state == S_START) begin
            timer <= '0;
         end else if ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) begin
            timer <= timer + TW'(1);
         end

         if (fail) begin
            backoff_cnt <= BACKOFF_LAST;
         end else if ((state == S_BACKOFF) && (backoff_cnt != '0)) begin
            backoff_cnt <= backoff_cnt - BW'(1);
         end

         if (capture) begin
            retry_cnt <= 4'd0;
         end else if (fail && (retry_cnt < RETRY_LIMIT)) begin
            retry_cnt <= retry_cnt + 4'd1;
         end else if ((state == S_FAULT) && clear_fault) begin
            retry_cnt <= 4'd0;
         end

         if (fail) begin
            last_err <= fail_code;
         end
      end
   end

   // ---------------------------------------------------------------------------------
   // One-deep output buffer
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data     <= '0;
         out_valid    <= 1'b0;
         overrun      <= 1'b0;
         sample_count <= 16'd0;
      end else begin
         if (capture) begin
            out_data     <= bme_data;
            out_valid    <= 1'b1;
            sample_count <= sample_count + 16'd1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         // A fresh overwrite outranks a coincident clear so no lost sample goes unflagged.
         if (capture && out_valid && !out_ready) begin
            overrun <= 1'b1;
         end else if (clear_fault) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bme280_sample_scheduler.sv
`default_nettype none
// Bench for bme280_sample_scheduler: scripted core model, transaction-level output
// buffer model, directed scenarios followed by a randomized traffic phase.
module tb_bme280_sample_scheduler;

   localparam int DW        = 96;
   localparam int INTERVAL  = 20;
   localparam int TIMEOUT   = 50;
   localparam int BACKOFF   = 8;
   localparam int MAX_RETRY = 2;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           run = 1'b0;
   logic           trigger = 1'b0;
   logic           clear_fault = 1'b0;
   logic           bme_enable;
   logic           bme_continuous;
   logic           bme_busy = 1'b0;
   logic           bme_valid = 1'b0;
   logic [1:0]     bme_error = 2'b00;
   logic [DW-1:0]  bme_data = '0;
   logic [DW-1:0]  out_data;
   logic           out_valid;
   logic           out_ready;
   logic           overrun;
   logic           fault;
   logic [2:0]     last_err;
   logic [15:0]    sample_count;

   logic           rdy_drv = 1'b0;
   logic           rdy_hs = 1'b0;
   assign out_ready = rdy_drv | (rdy_hs & bme_valid);

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bme280_sample_scheduler #(
      .DATA_W      (DW),
      .INTERVAL_CYC(INTERVAL),
      .TIMEOUT_CYC (TIMEOUT),
      .BACKOFF_CYC (BACKOFF),
      .MAX_RETRY   (MAX_RETRY)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .run           (run),
      .trigger       (trigger),
      .clear_fault   (clear_fault),
      .bme_enable    (bme_enable),
      .bme_continuous(bme_continuous),
      .bme_busy      (bme_busy),
      .bme_valid     (bme_valid),
      .bme_error     (bme_error),
      .bme_data      (bme_data),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .overrun       (overrun),
      .fault         (fault),
      .last_err      (last_err),
      .sample_count  (sample_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Core response scripts (written by stimulus) and enable log (written by core model)
   int          sc_delay [256];
   logic [1:0]  sc_err   [256];
   bit          sc_silent[256];
   bit          sc_busy  [256];
   int          sc_wr = 0;
   int          sc_rd = 0;
   int          en_log [256];
   int          en_n = 0;
   int          spur_cyc = -1;

   bit          act = 1'b0;
   bit          genuine = 1'b0;
   bit          cur_s = 1'b0;
   bit          cur_b = 1'b0;
   logic [1:0]  cur_e = 2'b00;
   int          remain = 0;

   always @(negedge clk) begin
      bme_valid <= 1'b0;
      genuine   <= 1'b0;
      if (!reset_n) begin
         act      <= 1'b0;
         bme_busy <= 1'b0;
      end else if (bme_enable) begin
         en_log[8'(en_n)] <= cyc;
         en_n     <= en_n + 1;
         act      <= 1'b1;
         bme_busy <= 1'b0;
         if (sc_rd != sc_wr) begin
            cur_e  <= sc_err[8'(sc_rd)];
            cur_s  <= sc_silent[8'(sc_rd)];
            cur_b  <= sc_busy[8'(sc_rd)];
            remain <= sc_delay[8'(sc_rd)] - 1;
            sc_rd  <= sc_rd + 1;
         end else begin
            cur_e  <= 2'b00;
            cur_s  <= 1'b0;
            cur_b  <= 1'b1;
            remain <= 2;
         end
      end else if (act) begin
         if (cur_s) begin
            bme_busy <= cur_b;
         end else if (remain == 0) begin
            bme_valid <= 1'b1;
            genuine   <= 1'b1;
            bme_error <= cur_e;
            bme_data  <= {$urandom, $urandom, $urandom};
            bme_busy  <= 1'b0;
            act       <= 1'b0;
         end else begin
            bme_busy <= cur_b;
            remain   <= remain - 1;
         end
      end
      if (reset_n && (cyc == spur_cyc)) begin
         bme_valid <= 1'b1;
         bme_error <= 2'b00;
         bme_data  <= {$urandom, $urandom, $urandom};
      end
   end

   // Output buffer model: good core answers become samples; stray strobes are ignored.
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_data = '0;
   logic [15:0]   m_cnt = 16'd0;
   logic          m_ovr = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_cnt   <= 16'd0;
         m_ovr   <= 1'b0;
      end else begin
         if (clear_fault) m_ovr <= 1'b0;
         if (bme_valid && genuine && (bme_error == 2'b00)) begin
            if (m_valid && !out_ready) m_ovr <= 1'b1;
            m_valid <= 1'b1;
            m_data  <= bme_data;
            m_cnt   <= m_cnt + 16'd1;
         end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
      if (!reset_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_count", sample_count, 0);
         chk("rst_overrun", overrun, 0);
      end else begin
         chk("out_valid", out_valid, m_valid);
         chk("out_data", out_data, m_data);
         chk("sample_count", sample_count, m_cnt);
         chk("overrun", overrun, m_ovr);
      end
      chk("continuous", bme_continuous, 0);
   endtask

   task automatic push(input int d, input logic [1:0] e, input bit s, input bit b);
      sc_delay[8'(sc_wr)]  = d;
      sc_err[8'(sc_wr)]    = e;
      sc_silent[8'(sc_wr)] = s;
      sc_busy[8'(sc_wr)]   = b;
      sc_wr++;
   endtask

   task automatic pulse_trigger();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
   endtask

   task automatic wait_enables(input int target, input int budget, input string tag);
      int n = 0;
      while ((en_n < target) && (n < budget)) begin
         tick();
         n++;
      end
      chk(tag, en_n, target);
   endtask

   task automatic wait_count(input logic [15:0] target, input int budget, input string tag);
      int n = 0;
      while ((sample_count != target) && (n < budget)) begin
         tick();
         n++;
      end
      chk(tag, sample_count, target);
   endtask

   task automatic wait_cyc(input int c);
      int n = 0;
      while ((cyc < c) && (n < 1000)) begin
         tick();
         n++;
      end
   endtask

   function automatic int en_at(input int i);
      return en_log[8'(i)];
   endfunction

   initial begin
      int base, c0, s0, d, cnt0;
      logic [1:0] e1, e2;
      bit prev_err;

      // Reset state
      #1;
      chk("reset_enable", bme_enable, 0);
      chk("reset_fault", fault, 0);
      chk("reset_last_err", last_err, 0);
      chk("reset_out_data", out_data, 0);
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (30) tick();
      chk("idle_quiet", en_n, 0);

      // Periodic sampling
      rdy_drv = 1'b1;
      for (int k = 0; k < 4; k++) push($urandom_range(1, 15), 2'b00, 1'b0, 1'($urandom_range(0, 1)));
      base = en_n;
      c0 = cyc;
      run = 1'b1;
      wait_enables(base + 4, 200, "periodic_enables");
      for (int k = 0; k < 4; k++) chk("periodic_time", en_at(base + k), c0 + INTERVAL * (k + 1));
      run = 1'b0;
      repeat (30) tick();
      chk("periodic_count", sample_count, 4);

      // Overrun on unconsumed overwrite, stray strobe ignored, clear_fault clears overrun
      rdy_drv = 1'b0;
      push($urandom_range(1, 10), 2'b00, 1'b0, 1'b1);
      push($urandom_range(1, 10), 2'b00, 1'b0, 1'b0);
      pulse_trigger();
      wait_count(m_cnt + 16'd1, 40, "ovr_first");
      chk("ovr_clean", overrun, 0);
      pulse_trigger();
      wait_count(m_cnt + 16'd1, 40, "ovr_second");
      chk("ovr_set", overrun, 1);
      chk("ovr_data", out_data, m_data);
      cnt0 = int'(sample_count);
      spur_cyc = cyc + 2;
      repeat (6) tick();
      chk("stray_valid_ignored", sample_count, cnt0);
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      tick();
      chk("ovr_cleared", overrun, 0);
      chk("ovr_still_valid", out_valid, 1);
      rdy_drv = 1'b1;
      repeat (2) tick();
      chk("drained", out_valid, 0);

      // Error retries then success
      d  = $urandom_range(2, 9);
      e1 = 2'($urandom_range(1, 3));
      e2 = 2'($urandom_range(1, 3));
      push(d, e1, 1'b0, 1'b1);
      push(d, e2, 1'b0, 1'b0);
      push(d, 2'b00, 1'b0, 1'b1);
      base = en_n;
      cnt0 = int'(sample_count);
      pulse_trigger();
      wait_enables(base + 3, 200, "retry_enables");
      chk("retry_gap1", en_at(base + 1) - en_at(base), d + BACKOFF + 1);
      chk("retry_gap2", en_at(base + 2) - en_at(base + 1), d + BACKOFF + 1);
      wait_count(16'(cnt0 + 1), 40, "retry_capture");
      chk("retry_last_err", last_err, {1'b0, e2});
      chk("retry_no_fault", fault, 0);

      // Silent core: timeouts until retries are exhausted
      for (int k = 0; k <= MAX_RETRY; k++) push(1, 2'b00, 1'b1, 1'($urandom_range(0, 1)));
      base = en_n;
      pulse_trigger();
      wait_enables(base + MAX_RETRY + 1, (MAX_RETRY + 1) * (TIMEOUT + BACKOFF + 1) + 20, "timeout_enables");
      for (int k = 1; k <= MAX_RETRY; k++)
         chk("timeout_gap", en_at(base + k) - en_at(base + k - 1), TIMEOUT + BACKOFF + 1);
      s0 = en_at(base + MAX_RETRY);
      wait_cyc(s0 + TIMEOUT);
      chk("fault_not_yet", fault, 0);
      tick();
      chk("fault_entered", fault, 1);
      chk("timeout_last_err", last_err, 3'b100);
      pulse_trigger();
      repeat (20) tick();
      chk("fault_ignores_trigger", en_n, base + MAX_RETRY + 1);
      chk("fault_held", fault, 1);
      trigger = 1'b1;
      clear_fault = 1'b1;
      tick();
      trigger = 1'b0;
      clear_fault = 1'b0;
      chk("fault_cleared", fault, 0);
      repeat (20) tick();
      chk("clear_drops_trigger", en_n, base + MAX_RETRY + 1);
      chk("last_err_kept", last_err, 3'b100);
      push(3, 2'b00, 1'b0, 1'b1);
      cnt0 = int'(sample_count);
      pulse_trigger();
      wait_count(16'(cnt0 + 1), 40, "after_clear_capture");

      // Trigger plus interval expiry during a long transaction: one pending start
      push(30, 2'b00, 1'b0, 1'b1);
      push(5, 2'b00, 1'b0, 1'b1);
      base = en_n;
      pulse_trigger();
      wait_enables(base + 1, 10, "pend_first");
      s0 = en_at(base);
      wait_cyc(s0 + 1);
      run = 1'b1;
      wait_cyc(s0 + 5);
      pulse_trigger();
      wait_cyc(s0 + 25);
      run = 1'b0;
      wait_enables(base + 2, 60, "pend_second");
      chk("pend_time", en_at(base + 1), s0 + 32);
      repeat (60) tick();
      chk("pend_single", en_n, base + 2);

      // Async reset in the middle of a transaction
      rdy_drv = 1'b0;
      push(3, 2'b00, 1'b0, 1'b0);
      push(30, 2'b00, 1'b0, 1'b1);
      cnt0 = int'(sample_count);
      pulse_trigger();
      wait_count(16'(cnt0 + 1), 30, "pre_reset_capture");
      base = en_n;
      pulse_trigger();
      wait_enables(base + 1, 10, "pre_reset_enable");
      wait_cyc(en_at(base) + 10);
      chk("pre_reset_valid", out_valid, 1);
      reset_n = 1'b0;
      #1;
      chk("arst_enable", bme_enable, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_count", sample_count, 0);
      chk("arst_last_err", last_err, 0);
      chk("arst_data", out_data, 0);
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (100) tick();
      chk("no_resume", en_n, base + 1);

      // Capture in the same cycle as a handshake
      push(4, 2'b00, 1'b0, 1'b1);
      push(4, 2'b00, 1'b0, 1'b1);
      pulse_trigger();
      wait_count(16'd1, 30, "hs_first");
      rdy_hs = 1'b1;
      pulse_trigger();
      wait_count(16'd2, 30, "hs_second");
      rdy_hs = 1'b0;
      chk("hs_valid_kept", out_valid, 1);
      chk("hs_no_overrun", overrun, 0);
      rdy_drv = 1'b1;
      repeat (3) tick();

      // Randomized traffic
      prev_err = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ((sc_wr - sc_rd) < 2) begin
            if (!prev_err && ($urandom_range(0, 4) == 0)) begin
               push($urandom_range(1, 15), 2'($urandom_range(1, 3)), 1'b0, 1'($urandom_range(0, 1)));
               prev_err = 1'b1;
            end else begin
               push($urandom_range(1, 15), 2'b00, 1'b0, 1'($urandom_range(0, 1)));
               prev_err = 1'b0;
            end
         end
         rdy_drv     = 1'($urandom_range(0, 1));
         trigger     = ($urandom_range(0, 24) == 0);
         clear_fault = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 199) == 0) run = ~run;
         tick();
      end
      trigger = 1'b0;
      clear_fault = 1'b0;
      run = 1'b0;
      rdy_drv = 1'b1;
      repeat (200) tick();
      chk("rand_no_fault", fault, 0);
      chk("rand_count", sample_count, m_cnt);
      chk("rand_drained", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
